// File: rtl/mc_ctrl.sv
// Multi-cycle main controller: Moore FSM sequencing FETCH/DECODE/EXECUTE/MEM/WRITEBACK.
// Optional retired-instruction counter enabled by defining CTRL_PERF_CNT_EN.
module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       PCWr,
    output logic [1:0] NPCSel,
    output logic       IRWr,
    output logic       RegWr,
    output logic [1:0] RegDst,
    output logic [1:0] WdSel,
    output logic       ALUSrc,
    output logic [1:0] ALUOp,
    output logic [1:0] ExtOp,
    output logic       MemWr,
    output logic [3:0] state
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] instr_cnt
`endif
);

    localparam logic [3:0] S_FETCH = 4'd0;
    localparam logic [3:0] S_DCD   = 4'd1;
    localparam logic [3:0] S_EXE   = 4'd2;
    localparam logic [3:0] S_AWB   = 4'd3;
    localparam logic [3:0] S_MADR  = 4'd4;
    localparam logic [3:0] S_MRD   = 4'd5;
    localparam logic [3:0] S_MWB   = 4'd6;
    localparam logic [3:0] S_MWR   = 4'd7;
    localparam logic [3:0] S_BR    = 4'd8;
    localparam logic [3:0] S_JMP   = 4'd9;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_JR    = 6'h08;

    logic       is_r, is_addu, is_subu, is_jr, is_ori, is_lui;
    logic       is_lw, is_sw, is_beq, is_j, is_jal;
    logic       is_alu, is_mem, is_jmp;
    logic [3:0] next_state;
    logic       pc_wr, ir_wr, reg_wr, mem_wr;

    assign is_r    = (op == OP_RTYPE);
    assign is_addu = is_r && (funct == FN_ADDU);
    assign is_subu = is_r && (funct == FN_SUBU);
    assign is_jr   = is_r && (funct == FN_JR);
    assign is_ori  = (op == OP_ORI);
    assign is_lui  = (op == OP_LUI);
    assign is_lw   = (op == OP_LW);
    assign is_sw   = (op == OP_SW);
    assign is_beq  = (op == OP_BEQ);
    assign is_j    = (op == OP_J);
    assign is_jal  = (op == OP_JAL);
    assign is_alu  = is_addu || is_subu || is_ori || is_lui;
    assign is_mem  = is_lw || is_sw;
    assign is_jmp  = is_j || is_jal || is_jr;

    // NOTE: every output gets a default before the case, so no path leaves a latch behind.
    always_comb begin
        next_state = S_FETCH;
        pc_wr      = 1'b0;
        ir_wr      = 1'b0;
        reg_wr     = 1'b0;
        mem_wr     = 1'b0;
        NPCSel     = 2'b00;
        RegDst     = 2'b00;
        WdSel      = 2'b00;
        ALUSrc     = 1'b0;
        ALUOp      = 2'b00;
        ExtOp      = 2'b00;
        case (state)
            S_FETCH: begin
                ir_wr      = 1'b1;
                next_state = S_DCD;
            end
            S_DCD: begin
                if (is_alu)      next_state = S_EXE;
                else if (is_mem) next_state = S_MADR;
                else if (is_beq) next_state = S_BR;
                else if (is_jmp) next_state = S_JMP;
                else             pc_wr      = 1'b1;  // illegal op retires as a NOP
            end
            S_EXE, S_AWB: begin
                if (is_r) begin
                    ALUOp = is_subu ? 2'b01 : 2'b00;
                end else begin
                    ALUSrc = 1'b1;
                    ALUOp  = is_ori ? 2'b10 : 2'b00;
                    ExtOp  = is_lui ? 2'b10 : 2'b00;
                end
                if (state == S_EXE) begin
                    next_state = S_AWB;
                end else begin
                    reg_wr = 1'b1;
                    RegDst = is_r ? 2'b01 : 2'b00;
                    pc_wr  = 1'b1;
                end
            end
            S_MADR, S_MRD, S_MWR: begin
                ALUSrc = 1'b1;
                ExtOp  = 2'b01;
                if (state == S_MADR) begin
                    next_state = is_lw ? S_MRD : S_MWR;
                end else if (state == S_MRD) begin
                    next_state = S_MWB;
                end else begin
                    mem_wr = 1'b1;
                    pc_wr  = 1'b1;
                end
            end
            S_MWB: begin
                reg_wr = 1'b1;
                WdSel  = 2'b01;
                pc_wr  = 1'b1;
            end
            S_BR: begin
                ALUOp  = 2'b01;
                pc_wr  = 1'b1;
                NPCSel = zero ? 2'b11 : 2'b00;
            end
            S_JMP: begin
                pc_wr  = 1'b1;
                NPCSel = is_jr ? 2'b01 : 2'b10;
                if (is_jal) begin
                    reg_wr = 1'b1;
                    RegDst = 2'b10;
                    WdSel  = 2'b10;
                end
            end
            default: ;
        endcase
    end

    // Strobes are masked while reset is held so an aborted instruction never writes.
    assign PCWr  = pc_wr  & reset;
    assign IRWr  = ir_wr  & reset;
    assign RegWr = reg_wr & reset;
    assign MemWr = mem_wr & reset;

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_FETCH;
        else        state <= next_state;
    end

`ifdef CTRL_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    instr_cnt <= '0;
        else if (PCWr) instr_cnt <= instr_cnt + CNT_W'(1);
    end
`endif

endmodule
